// File: rtl/oc3_sweep_ctrl_pkg.sv
// Shared types, Gray stimulus table and golden model for the ones-counter sweep.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oc3_pkg;

    localparam int N_IMPL = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } oc3_state_e;

    // {a,b,c} per step; adjacent entries differ in exactly one bit, no wrap to 000.
    localparam logic [2:0] GRAY [0:7] = '{
        3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
    };

    // Number of ones among a, b, c as {y1,y0}.
    function automatic logic [1:0] oc3_golden(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/oc3_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment (stimulus out, DUT responses in).
// Latency: n/a (wiring only).
// Backpressure: none; start is a level sampled only while the controller is idle/done.
interface oc3_sweep_ctrl_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic [1:0] y_sl;
    logic [1:0] y_gl;
    logic [1:0] y_ass;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_vec;
    logic [3:0] fail_count;
    logic [2:0] first_fail;

    // Environment side: issues start and returns the implementations' outputs.
    modport master (
        output start, y_sl, y_gl, y_ass,
        input  a, b, c, busy, done, pass, err_vec, fail_count, first_fail
    );

    // Controller side.
    modport slave (
        input  start, y_sl, y_gl, y_ass,
        output a, b, c, busy, done, pass, err_vec, fail_count, first_fail
    );
endinterface

// File: rtl/oc3_sweep_ctrl_result_rec.sv
// Sticky per-implementation error flags, failing-vector count and first failing vector.
// Latency: results update on the clock edge that ends the sample cycle.
// Backpressure: none; clear and sample are single-cycle strobes from the FSM.
module oc3_result_rec
    import oc3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample,
    input  logic [N_IMPL-1:0] mismatch,
    input  logic [2:0]        vec,
    output logic [N_IMPL-1:0] err_vec,
    output logic [3:0]        fail_count,
    output logic [2:0]        first_fail
);

    logic [N_IMPL-1:0] err_vec_q, err_vec_d;
    logic [3:0]        fail_count_q, fail_count_d;
    logic [2:0]        first_fail_q, first_fail_d;

    // Accumulate mismatches; first_fail is captured while no failure has been counted yet.
    always_comb begin
        err_vec_d    = err_vec_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        if (clear) begin
            err_vec_d    = '0;
            fail_count_d = '0;
            first_fail_d = '0;
        end else if (sample && (|mismatch)) begin
            err_vec_d    = err_vec_q | mismatch;
            fail_count_d = fail_count_q + 4'd1;
            if (fail_count_q == 4'd0) begin
                first_fail_d = vec;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_vec_q    <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            err_vec_q    <= err_vec_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign err_vec    = err_vec_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

endmodule

// File: rtl/oc3_sweep_ctrl.sv
// Clocked Gray-order sweep of a/b/c with settle delay, checking three ones-counter impls.
// Latency: done rises 8*(SETTLE_CYCLES+1) clocks after the edge that captures start.
// Backpressure: start is ignored while busy; results hold in DONE until the next start.
module oc3_sweep_ctrl
    import oc3_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    oc3_sweep_ctrl_if.slave    bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    oc3_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        abc_q, abc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rec_clear;
    logic              rec_sample;
    logic [1:0]        golden;
    logic [N_IMPL-1:0] mismatch;
    logic [N_IMPL-1:0] err_vec;

    // Golden count of the held vector; case inequality so X/Z responses count as failures.
    always_comb begin
        golden   = oc3_golden(abc_q[2], abc_q[1], abc_q[0]);
        mismatch = {(bus.y_ass !== golden), (bus.y_gl !== golden), (bus.y_sl !== golden)};
    end

    // Next-state logic: start -> (SETTLE -> SAMPLE) x 8 -> DONE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        abc_d      = abc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        rec_clear  = 1'b0;
        rec_sample = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    rec_clear = 1'b1;
                    abc_d     = GRAY[0];
                    idx_d     = 3'd0;
                    cnt_d     = CNT_LOAD;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                rec_sample = 1'b1;
                if (idx_q == 3'd7) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    abc_d   = GRAY[idx_q + 3'd1];
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counters and stimulus registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    oc3_result_rec u_rec (
        .clk        (clk),
        .rst        (rst),
        .clear      (rec_clear),
        .sample     (rec_sample),
        .mismatch   (mismatch),
        .vec        (abc_q),
        .err_vec    (err_vec),
        .fail_count (bus.fail_count),
        .first_fail (bus.first_fail)
    );

    assign bus.a       = abc_q[2];
    assign bus.b       = abc_q[1];
    assign bus.c       = abc_q[0];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err_vec = err_vec;
    assign bus.pass    = done_q && (err_vec == '0);

endmodule

// File: tb/tb_oc3_sweep_ctrl.sv
// Directed bench for oc3_sweep_ctrl: clean sweep, injected faults, stimulus order, reset, restart.
// Latency: expects done 40 clocks after the start-capturing edge (SETTLE_CYCLES=4).
// Backpressure: start held high must not restart a running sweep.
module tb_oc3_sweep_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   fault_mode;   // 0 = all golden, 1 = y_gl stuck 00, 2 = y_sl[0] flipped at 111

    oc3_sweep_ctrl_if bus ();

    oc3_sweep_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-ins for the three implementations.
    always @* begin
        logic [1:0] cnt;
        cnt = 2'(int'(bus.a) + int'(bus.b) + int'(bus.c));
        bus.y_sl  = cnt;
        bus.y_gl  = cnt;
        bus.y_ass = cnt;
        if (fault_mode == 1) bus.y_gl = 2'b00;
        if (fault_mode == 2 && {bus.a, bus.b, bus.c} == 3'b111) bus.y_sl = cnt ^ 2'b01;
    end

    localparam logic [2:0] EXP_GRAY [0:7] = '{
        3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100
    };

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse (or hold) start, then count clocks from the capture edge until done.
    task automatic start_and_wait(input bit hold, output int n);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        n = 0;
        while (n < 200 && bus.done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b required=000000",
                     {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass});
        end
        checks++;
        if ({bus.err_vec, bus.fail_count, bus.first_fail} !== 10'b0) begin
            failures++;
            $display("FAIL reset_results actual=%b required=0", {bus.err_vec, bus.fail_count, bus.first_fail});
        end
    endtask

    task automatic test_clean_sweep();
        int n;
        fault_mode = 0;
        start_and_wait(1'b0, n);
        checks++;
        if (n != 40) begin failures++; $display("FAIL clean_latency actual=%0d required=40", n); end
        checks++;
        if ({bus.pass, bus.busy, bus.err_vec} !== 5'b10000) begin
            failures++; $display("FAIL clean_pass actual=%b required=10000", {bus.pass, bus.busy, bus.err_vec});
        end
        checks++;
        if (bus.fail_count !== 4'd0 || bus.first_fail !== 3'b000) begin
            failures++; $display("FAIL clean_counts actual=%0d/%b required=0/000", bus.fail_count, bus.first_fail);
        end
    endtask

    task automatic test_gl_stuck();
        int n;
        fault_mode = 1;
        start_and_wait(1'b0, n);
        checks++;
        if (bus.err_vec !== 3'b010 || bus.pass !== 1'b0) begin
            failures++; $display("FAIL gl_err actual=%b pass=%b required=010 pass=0", bus.err_vec, bus.pass);
        end
        checks++;
        if (bus.fail_count !== 4'd7) begin failures++; $display("FAIL gl_count actual=%0d required=7", bus.fail_count); end
        checks++;
        if (bus.first_fail !== 3'b001) begin failures++; $display("FAIL gl_first actual=%b required=001", bus.first_fail); end
    endtask

    task automatic test_sl_111();
        int n;
        fault_mode = 2;
        start_and_wait(1'b0, n);
        checks++;
        if (bus.err_vec !== 3'b001 || bus.pass !== 1'b0) begin
            failures++; $display("FAIL sl_err actual=%b pass=%b required=001 pass=0", bus.err_vec, bus.pass);
        end
        checks++;
        if (bus.fail_count !== 4'd1 || bus.first_fail !== 3'b111) begin
            failures++; $display("FAIL sl_counts actual=%0d/%b required=1/111", bus.fail_count, bus.first_fail);
        end
    endtask

    // Cycle k after the capture edge must show GRAY[k/5]; then 100 held in DONE.
    task automatic test_gray_monitor();
        int bad;
        logic [2:0] prev, cur;
        fault_mode = 0;
        bad = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        prev = {bus.a, bus.b, bus.c};
        for (int k = 0; k < 40; k++) begin
            cur = {bus.a, bus.b, bus.c};
            if (cur !== EXP_GRAY[k / 5] || $countones(cur ^ prev) > 1) begin
                if (bad == 0) $display("FAIL gray_step k=%0d actual=%b required=%b", k, cur, EXP_GRAY[k / 5]);
                bad++;
            end
            prev = cur;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) failures++;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({bus.a, bus.b, bus.c} !== 3'b100 || bus.done !== 1'b1) begin
            failures++; $display("FAIL gray_done_hold actual=%b done=%b required=100 done=1", {bus.a, bus.b, bus.c}, bus.done);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        fault_mode = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        checks++;
        if ({bus.a, bus.b, bus.c} !== 3'b010 || bus.err_vec !== 3'b010) begin
            failures++; $display("FAIL mid_vec3 abc=%b err=%b required=010/010", {bus.a, bus.b, bus.c}, bus.err_vec);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass, bus.err_vec, bus.fail_count, bus.first_fail} !== 16'b0) begin
            failures++; $display("FAIL mid_rst_async actual=%b required=0",
                {bus.a, bus.b, bus.c, bus.busy, bus.done, bus.pass, bus.err_vec, bus.fail_count, bus.first_fail});
        end
        @(negedge clk);
        rst = 1'b0;
        fault_mode = 0;
        start_and_wait(1'b0, n);
        checks++;
        if (n != 40 || bus.pass !== 1'b1 || bus.fail_count !== 4'd0) begin
            failures++; $display("FAIL post_rst_sweep n=%0d pass=%b cnt=%0d required=40/1/0", n, bus.pass, bus.fail_count);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        fault_mode = 1;
        start_and_wait(1'b1, n);
        checks++;
        if (n != 40 || bus.fail_count !== 4'd7 || bus.first_fail !== 3'b001) begin
            failures++; $display("FAIL hold_start n=%0d cnt=%0d first=%b required=40/7/001", n, bus.fail_count, bus.first_fail);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.err_vec !== 3'b010) begin
            failures++; $display("FAIL done_stable done=%b busy=%b err=%b required=1/0/010", bus.done, bus.busy, bus.err_vec);
        end
        fault_mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.err_vec, bus.fail_count, bus.a, bus.b, bus.c} !== {2'b10, 10'b0}) begin
            failures++; $display("FAIL restart_clear busy=%b done=%b err=%b cnt=%0d abc=%b", bus.busy, bus.done,
                                 bus.err_vec, bus.fail_count, {bus.a, bus.b, bus.c});
        end
        n = 0;
        while (n < 200 && bus.done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 40 || bus.pass !== 1'b1 || bus.err_vec !== 3'b000 || bus.first_fail !== 3'b000) begin
            failures++; $display("FAIL restart_result n=%0d pass=%b err=%b first=%b required=40/1/000/000",
                                 n, bus.pass, bus.err_vec, bus.first_fail);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        fault_mode = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        test_reset();
        test_clean_sweep();
        test_gl_stuck();
        test_sl_111();
        test_gray_monitor();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
